powerup_ctrl: RTL and testbench

- Lifecycle controller for the 16x16 powerup sprite: decides when and where a powerup spawns, animates its fall, expires it, detects pickup by either player head and issues a one-cycle grant.
- Drives the sprite source's x0/y0 origin and a visibility/type select.
- Sits between the frame-timing logic, player position registers and the powerup sprite renderer.
- Status is readable by MicroBlaze through its MMIO wrapper.

---
 rtl/powerup_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_powerup_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/powerup_ctrl.sv
// -----------------------------------------------------------------------------
// powerup_ctrl
// Lifecycle controller for the 16x16 powerup sprite. It decides when and where
// a powerup spawns, animates its fall, expires it, detects pickup by either
// player head and issues a one-cycle grant pulse.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   enable                1 = game running, 0 = freeze counters and collision
//   clear                 one-cycle pulse: despawn and restart the wait
//   p1_x/p1_y, p2_x/p2_y  player head top-left positions (11 bit)
//   pu_x0, pu_y0          sprite origin (11 bit)
//   pu_visible            sprite enabled
//   pu_type               powerup kind
//   grant_p1, grant_p2    one-cycle pickup pulses
//   pu_state              00 WAIT, 01 SPAWN, 10 ACTIVE, 11 GRANT
//
// Optional build macro:
//   POWERUP_BLINK_EN      blink the sprite (bit 3 of a frame counter) during
//                         the last 120 frames of its life
// -----------------------------------------------------------------------------
module powerup_ctrl #(
   parameter int unsigned SPAWN_MIN = 180,
   parameter int unsigned LIFETIME  = 600,
   parameter int unsigned SPR       = 16,
   parameter int unsigned HEAD      = 32,
   parameter int unsigned X_MIN     = 64,
   parameter int unsigned X_MAX     = 560,
   parameter int unsigned Y_SPAWN   = 0,
   parameter int unsigned Y_GROUND  = 400,
   parameter int unsigned FALL_STEP = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        enable,
   input  logic        clear,
   input  logic [10:0] p1_x,
   input  logic [10:0] p1_y,
   input  logic [10:0] p2_x,
   input  logic [10:0] p2_y,
   output logic [10:0] pu_x0,
   output logic [10:0] pu_y0,
   output logic        pu_visible,
   output logic [1:0]  pu_type,
   output logic        grant_p1,
   output logic        grant_p2,
   output logic [1:0]  pu_state
);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'b00,
      ST_SPAWN  = 2'b01,
      ST_ACTIVE = 2'b10,
      ST_GRANT  = 2'b11
   } state_t;

   localparam logic [15:0] CNT_SPAWN  = 16'(SPAWN_MIN);
   localparam logic [15:0] CNT_LIFE   = 16'(LIFETIME);
   localparam logic [11:0] SPR12      = 12'(SPR);
   localparam logic [11:0] HEAD12     = 12'(HEAD);
   localparam logic [11:0] XMIN12     = 12'(X_MIN);
   localparam logic [11:0] XMAX12     = 12'(X_MAX);
   localparam logic [10:0] YSPAWN11   = 11'(Y_SPAWN);
   localparam logic [11:0] YGROUND12  = 12'(Y_GROUND);
   localparam logic [11:0] FALL12     = 12'(FALL_STEP);
   localparam logic [15:0] LFSR_SEED  = 16'hACE1;
`ifdef POWERUP_BLINK_EN
   localparam logic [15:0] BLINK_LIFE = 16'd120;
`endif

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;      // WAIT countdown
   logic [15:0] life_q, life_d;    // ACTIVE lifetime
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic        vis_q, vis_d;
   logic [1:0]  type_q, type_d;
   logic        g1_q, g1_d;
   logic        g2_q, g2_d;
   logic        tie_q, tie_d;
   logic [15:0] lfsr_q, lfsr_d;
`ifdef POWERUP_BLINK_EN
   logic [15:0] fc_q, fc_d;
`endif

   logic [15:0] reload;
   logic [11:0] x_cand;
   logic [11:0] x_spawn;
   logic [11:0] y_sum;
   logic [10:0] y_fall;
   logic        hit1, hit2;
   logic        tick_en;

   // Head box (HEAD) against sprite box (SPR); 12-bit sums so nothing wraps.
   function automatic logic overlap(input logic [10:0] px, input logic [10:0] py,
                                    input logic [10:0] sx, input logic [10:0] sy);
      logic [11:0] px12, py12, sx12, sy12;
      px12 = {1'b0, px};
      py12 = {1'b0, py};
      sx12 = {1'b0, sx};
      sy12 = {1'b0, sy};
      return (sx12 < px12 + HEAD12) && (px12 < sx12 + SPR12) &&
             (sy12 < py12 + HEAD12) && (py12 < sy12 + SPR12);
   endfunction

   // Fibonacci LFSR, taps 16/14/13/11; free-running, nonzero seed keeps it off zero.
   assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   assign reload  = CNT_SPAWN + {8'h00, lfsr_q[7:0]};
   assign x_cand  = XMIN12 + {3'b000, lfsr_q[8:0]};
   // Fold overshoot back by 256 so the spawn x stays within [X_MIN, X_MAX].
   assign x_spawn = (x_cand > XMAX12) ? x_cand - 12'd256 : x_cand;
   assign y_sum   = {1'b0, y_q} + FALL12;
   assign y_fall  = (y_sum > YGROUND12) ? YGROUND12[10:0] : y_sum[10:0];
   assign hit1    = overlap(p1_x, p1_y, x_q, y_q);
   assign hit2    = overlap(p2_x, p2_y, x_q, y_q);
   assign tick_en = frame_tick & enable;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      life_d  = life_q;
      x_d     = x_q;
      y_d     = y_q;
      vis_d   = vis_q;
      type_d  = type_q;
      g1_d    = 1'b0;
      g2_d    = 1'b0;
      tie_d   = tie_q;
`ifdef POWERUP_BLINK_EN
      fc_d    = fc_q;
`endif
      if (clear) begin
         state_d = ST_WAIT;
         vis_d   = 1'b0;
         cnt_d   = reload;
      end else begin
         unique case (state_q)
            ST_WAIT: begin
               if (tick_en) begin
                  if (cnt_q <= 16'd1) begin
                     cnt_d   = '0;
                     state_d = ST_SPAWN;
                  end else begin
                     cnt_d   = cnt_q - 16'd1;
                  end
               end
            end
            // Completes regardless of enable.
            ST_SPAWN: begin
               x_d     = x_spawn[10:0];
               y_d     = YSPAWN11;
               type_d  = lfsr_q[11:10];
               life_d  = CNT_LIFE;
               vis_d   = 1'b1;
               state_d = ST_ACTIVE;
`ifdef POWERUP_BLINK_EN
               fc_d    = '0;
`endif
            end
            ST_ACTIVE: begin
               if (enable) begin
                  // Pickup wins over fall/expiry in the same cycle.
                  if (hit1 || hit2) begin
                     state_d = ST_GRANT;
                     vis_d   = 1'b0;
                     if (hit1 && hit2) begin
                        g1_d  = ~tie_q;
                        g2_d  = tie_q;
                        tie_d = ~tie_q;
                     end else begin
                        g1_d  = hit1;
                        g2_d  = hit2;
                     end
                  end else if (frame_tick) begin
                     y_d    = y_fall;
                     life_d = life_q - 16'd1;
                     if (life_q <= 16'd1) begin
                        life_d  = '0;
                        vis_d   = 1'b0;
                        cnt_d   = reload;
                        state_d = ST_WAIT;
                     end else begin
`ifdef POWERUP_BLINK_EN
                        fc_d  = fc_q + 16'd1;
                        vis_d = (life_d < BLINK_LIFE) ? ~fc_d[3] : 1'b1;
`else
                        vis_d = 1'b1;
`endif
                     end
                  end
               end
            end
            ST_GRANT: begin
               cnt_d   = reload;
               state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT;
         cnt_q   <= CNT_SPAWN;
         life_q  <= '0;
         x_q     <= '0;
         y_q     <= YSPAWN11;
         vis_q   <= 1'b0;
         type_q  <= '0;
         g1_q    <= 1'b0;
         g2_q    <= 1'b0;
         tie_q   <= 1'b0;
         lfsr_q  <= LFSR_SEED;
`ifdef POWERUP_BLINK_EN
         fc_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         life_q  <= life_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vis_q   <= vis_d;
         type_q  <= type_d;
         g1_q    <= g1_d;
         g2_q    <= g2_d;
         tie_q   <= tie_d;
         lfsr_q  <= lfsr_d;
`ifdef POWERUP_BLINK_EN
         fc_q    <= fc_d;
`endif
      end
   end

   assign pu_x0      = x_q;
   assign pu_y0      = y_q;
   assign pu_visible = vis_q;
   assign pu_type    = type_q;
   assign grant_p1   = g1_q;
   assign grant_p2   = g2_q;
   assign pu_state   = state_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_powerup_ctrl
// Directed bench for powerup_ctrl: spawn timing and position, fall clamp,
// expiry, pickup (single, tie alternation, hitbox edge), clear, enable freeze
// and asynchronous reset. A reference LFSR predicts spawn x, type and the
// randomised wait reload.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_powerup_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        enable;
   logic        clear;
   logic [10:0] p1_x, p1_y, p2_x, p2_y;
   logic [10:0] pu_x0, pu_y0;
   logic        pu_visible;
   logic [1:0]  pu_type;
   logic        grant_p1, grant_p2;
   logic [1:0]  pu_state;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] m;        // reference LFSR
   logic [15:0] mcap;
   int          ex_x;
   int          reload_c;

   powerup_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .enable     (enable),
      .clear      (clear),
      .p1_x       (p1_x),
      .p1_y       (p1_y),
      .p2_x       (p2_x),
      .p2_y       (p2_y),
      .pu_x0      (pu_x0),
      .pu_y0      (pu_y0),
      .pu_visible (pu_visible),
      .pu_type    (pu_type),
      .grant_p1   (grant_p1),
      .grant_p2   (grant_p2),
      .pu_state   (pu_state)
   );

   always #5 clk = ~clk;

   // Taps 16,14,13,11 -> bits 15,13,12,10 -> mask 0xB400.
   always @(posedge clk or posedge reset) begin
      if (reset) m <= 16'hACE1;
      else       m <= {m[14:0], ^(m & 16'hB400)};
   end

   function automatic int calc_x(input logic [15:0] v);
      int c;
      c = 64 + int'(v[8:0]);
      if (c > 560) c = c - 256;
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ft);
      frame_tick = ft;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1);
   endtask

   task automatic far_players();
      p1_x = 11'd1500; p1_y = 11'd1500;
      p2_x = 11'd1700; p2_y = 11'd1700;
   endtask

   // Wait c frames in WAIT, then check SPAWN and the ACTIVE sprite it produces.
   task automatic spawn_after(input int c, input string tag);
      ticks(c - 1);
      chk({tag, "_still_wait"}, pu_state, 0);
      step(1'b1);
      chk({tag, "_spawn"}, pu_state, 1);
      mcap = m;
      ex_x = calc_x(mcap);
      step(1'b0);
      chk({tag, "_active"}, pu_state, 2);
      chk({tag, "_vis"}, pu_visible, 1);
      chk({tag, "_y0"}, pu_y0, 0);
      chk({tag, "_x0"}, pu_x0, ex_x);
      chk({tag, "_x_range"}, (pu_x0 >= 11'd64 && pu_x0 <= 11'd560), 1);
      chk({tag, "_type"}, pu_type, mcap[11:10]);
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; clear = 1'b0;
      far_players();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_state", pu_state, 0);
      chk("rst_vis", pu_visible, 0);
      chk("rst_x0", pu_x0, 0);
      chk("rst_y0", pu_y0, 0);
      chk("rst_type", pu_type, 0);
      chk("rst_g1", grant_p1, 0);
      chk("rst_g2", grant_p2, 0);

      // 1: first spawn on tick 180
      enable = 1'b1;
      spawn_after(180, "t1");

      // 2: fall clamp and expiry at tick 600
      ticks(199);
      chk("t2_y398", pu_y0, 398);
      step(1'b1);
      chk("t2_y400", pu_y0, 400);
      ticks(399);
      chk("t2_pre_exp_state", pu_state, 2);
      chk("t2_pre_exp_vis", pu_visible, 1);
      chk("t2_hold_y", pu_y0, 400);
      mcap = m;
      step(1'b1);
      chk("t2_exp_state", pu_state, 0);
      chk("t2_exp_vis", pu_visible, 0);
      reload_c = 180 + int'(mcap[7:0]);

      // 3: hitbox edge then single pickup by player 1
      spawn_after(reload_c, "t3");
      p1_x = 11'(ex_x - 32); p1_y = 11'd0;
      step(1'b0);
      chk("t3_edge_no_hit", pu_state, 2);
      chk("t3_edge_no_g1", grant_p1, 0);
      p1_x = 11'(ex_x - 31);
      step(1'b0);
      chk("t3_grant_state", pu_state, 3);
      chk("t3_g1", grant_p1, 1);
      chk("t3_g2", grant_p2, 0);
      chk("t3_vis", pu_visible, 0);
      mcap = m;
      far_players();
      step(1'b0);
      chk("t3_g1_drop", grant_p1, 0);
      chk("t3_wait", pu_state, 0);
      reload_c = 180 + int'(mcap[7:0]);

      // 4: simultaneous hits alternate p1 then p2
      spawn_after(reload_c, "t4a");
      p1_x = 11'(ex_x); p1_y = 11'd0; p2_x = 11'(ex_x); p2_y = 11'd0;
      step(1'b0);
      chk("t4a_g1", grant_p1, 1);
      chk("t4a_g2", grant_p2, 0);
      mcap = m;
      far_players();
      step(1'b0);
      reload_c = 180 + int'(mcap[7:0]);
      spawn_after(reload_c, "t4b");
      p1_x = 11'(ex_x); p1_y = 11'd0; p2_x = 11'(ex_x); p2_y = 11'd0;
      step(1'b0);
      chk("t4b_g1", grant_p1, 0);
      chk("t4b_g2", grant_p2, 1);
      mcap = m;
      far_players();
      step(1'b0);
      chk("t4b_wait", pu_state, 0);
      reload_c = 180 + int'(mcap[7:0]);

      // 5: clear during ACTIVE, then clear during GRANT
      spawn_after(reload_c, "t5a");
      ticks(5);
      clear = 1'b1;
      mcap = m;
      step(1'b0);
      clear = 1'b0;
      chk("t5a_state", pu_state, 0);
      chk("t5a_vis", pu_visible, 0);
      chk("t5a_g1", grant_p1, 0);
      chk("t5a_g2", grant_p2, 0);
      chk("t5a_y_hold", pu_y0, 10);
      reload_c = 180 + int'(mcap[7:0]);
      spawn_after(reload_c, "t5b");
      p1_x = 11'(ex_x); p1_y = 11'd0;
      step(1'b0);
      chk("t5b_grant", grant_p1, 1);
      far_players();
      clear = 1'b1;
      mcap = m;
      step(1'b0);
      clear = 1'b0;
      chk("t5b_state", pu_state, 0);
      chk("t5b_g1", grant_p1, 0);
      chk("t5b_vis", pu_visible, 0);
      reload_c = 180 + int'(mcap[7:0]);

      // 6: enable low freezes fall, life and collision
      spawn_after(reload_c, "t6");
      ticks(10);
      chk("t6_y20", pu_y0, 20);
      enable = 1'b0;
      p1_x = 11'(ex_x); p1_y = 11'd20;
      ticks(50);
      chk("t6_frozen_y", pu_y0, 20);
      chk("t6_frozen_state", pu_state, 2);
      chk("t6_no_grant", grant_p1, 0);
      far_players();
      step(1'b0);
      enable = 1'b1;
      ticks(589);
      chk("t6_life_state", pu_state, 2);
      chk("t6_life_y", pu_y0, 400);
      mcap = m;
      step(1'b1);
      chk("t6_expire", pu_state, 0);
      reload_c = 180 + int'(mcap[7:0]);

      // 7: asynchronous reset mid-ACTIVE
      spawn_after(reload_c, "t7");
      ticks(3);
      #2;
      reset = 1'b1;
      #1;
      chk("t7_rst_state", pu_state, 0);
      chk("t7_rst_vis", pu_visible, 0);
      chk("t7_rst_x0", pu_x0, 0);
      chk("t7_rst_y0", pu_y0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      spawn_after(180, "t7r");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
